// File: rtl/inv_key_expander.sv
// -----------------------------------------------------------------------------
// inv_key_expander
//   AES-128 round-key generator for the decryption datapath. Keys come out in
//   reverse order, round 10 first and round 0 last. A cipher key (round 0) is
//   first expanded forward ten rounds, one round per cycle. The schedule is then
//   walked backwards one round per rk handshake. A round-10 key can be loaded
//   directly, and in that case the forward pass is skipped.
//
//   Ports
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     key_in     cipher key (round 0) or last round key (round 10)
//                byte b at [8b+7:8b], word j at [32j+31:32j]
//     key_last   1: key_in is the round-10 key, 0: key_in is the cipher key
//     key_valid  key_in/key_last valid
//     key_ready  key can be accepted (high only in IDLE)
//     rk_out     current round key, zero whenever rk_valid is low
//     rk_round   round index of rk_out (10..0)
//     rk_valid   rk_out/rk_round valid
//     rk_ready   consumer takes the current round key
//     busy       high while expanding or emitting
//
//   NR must be 10. Only AES-128 is supported.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a key, key_ready high
//   EXPAND | forward schedule, one round per cycle until round 10
//   EMIT   | present rk_out, step backwards one round per handshake
// -----------------------------------------------------------------------------
module inv_key_expander #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_last,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

    state_t       state;
    logic [127:0] work;
    logic [3:0]   cnt;
    logic [127:0] fwd_key;
    logic [127:0] inv_key;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as x^254 (the GF(2^8) inverse, with 0 mapping to 0)
    // followed by the affine transform. This is a compact alternative to a
    // 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // The first key byte sits in the low bits. Rotating it to the top gives
    // the byte order [a1,a2,a3,a0].
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One forward round of the key schedule.
    function automatic logic [127:0] key_schedule(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] o0, o1, o2, o3;
        o0 = k[31:0] ^ {24'h0, rc} ^ sub_word(rot_word(k[127:96]));
        o1 = k[63:32]  ^ o0;
        o2 = k[95:64]  ^ o1;
        o3 = k[127:96] ^ o2;
        return {o3, o2, o1, o0};
    endfunction

    // One backward round. The words above w0 undo their XOR chain first.
    // That recovers the previous w3, which feeds the g-function for w0.
    function automatic logic [127:0] inv_schedule(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[127:96] ^ k[95:64];
        p2 = k[95:64]  ^ k[63:32];
        p1 = k[63:32]  ^ k[31:0];
        p0 = k[31:0] ^ {24'h0, rc} ^ sub_word(rot_word(p3));
        return {p3, p2, p1, p0};
    endfunction

    assign fwd_key = key_schedule(work, rcon(cnt + 4'd1));
    assign inv_key = inv_schedule(rk_out, rcon(rk_round));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            rk_out    <= '0;
            rk_round  <= '0;
            rk_valid  <= 1'b0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        key_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (key_last) begin
                            rk_out   <= key_in;
                            rk_round <= LAST;
                            rk_valid <= 1'b1;
                            state    <= EMIT;
                        end else begin
                            work  <= key_in;
                            cnt   <= '0;
                            state <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    work <= fwd_key;
                    cnt  <= cnt + 4'd1;
                    if (cnt == LAST - 4'd1) begin
                        rk_out   <= fwd_key;
                        rk_round <= LAST;
                        rk_valid <= 1'b1;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (rk_round == 4'd0) begin
                            rk_out    <= '0;
                            rk_valid  <= 1'b0;
                            key_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            rk_out   <= inv_key;
                            rk_round <= rk_round - 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_expander.sv
// -----------------------------------------------------------------------------
// tb_inv_key_expander
//   Directed bench for inv_key_expander. Expected round keys are the published
//   AES-128 expansions of the FIPS-197 example key and of the all-zero key.
//   Each word is byte-reversed into the low-byte-first packing of key_in.
// -----------------------------------------------------------------------------
module tb_inv_key_expander;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_last;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] fips_rk [0:10];
    logic [127:0] zero_rk [0:10];
    logic         zero_known [0:10];

    logic [127:0] beat_key   [0:10];
    logic [3:0]   beat_round [0:10];
    int           n_beats;
    int           lat;

    inv_key_expander #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_last  (key_last),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({tag, "_rk_valid"},  128'(rk_valid),  128'(0));
        chk({tag, "_rk_out"},    rk_out,          128'(0));
        chk({tag, "_busy"},      128'(busy),      128'(0));
        chk({tag, "_key_ready"}, 128'(key_ready), 128'(1));
    endtask

    task automatic idle_watch(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (rk_valid) seen = 1'b1;
        end
        chk(tag, 128'(seen), 128'(0));
    endtask

    // Present a key and wait for acceptance, then wait for the first rk beat
    // or until max_lat cycles have passed. lat counts cycles after the
    // acceptance edge. With hold set, key_valid stays high carrying a second
    // key, which the block must ignore while busy.
    task automatic send_key(input logic [127:0] k, input bit last, input bit hold,
                            input logic [127:0] other, input int max_lat, output int lat_o);
        int w;
        w = 0;
        key_in    = k;
        key_last  = last;
        key_valid = 1'b1;
        while (!key_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("key_ready_before_accept", 128'(key_ready), 128'(1));
        @(posedge clk); #1;
        if (hold) begin
            key_in   = other;
            key_last = 1'b0;
        end else begin
            key_valid = 1'b0;
        end
        lat_o = 1;
        while (!rk_valid && lat_o < max_lat) begin
            chk("expand_rk_out_zero", rk_out, 128'(0));
            chk("expand_key_ready",   128'(key_ready), 128'(0));
            chk("expand_busy",        128'(busy), 128'(1));
            @(posedge clk); #1;
            lat_o++;
        end
    endtask

    // Consume beats until 11 are taken. With bp set, rk_ready is randomized
    // and every stalled beat must hold its value into the next cycle.
    task automatic run_emit(input bit bp);
        int           cyc;
        bit           held;
        logic [127:0] hk;
        logic [3:0]   hr;
        cyc     = 0;
        held    = 1'b0;
        hk      = '0;
        hr      = '0;
        n_beats = 0;
        while (n_beats < 11 && cyc < 300) begin
            if (held) begin
                chk("stall_valid", 128'(rk_valid), 128'(1));
                chk("stall_key",   rk_out, hk);
                chk("stall_round", 128'(rk_round), 128'(hr));
            end
            rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 1'b0;
            if (rk_valid) begin
                chk("emit_key_ready", 128'(key_ready), 128'(0));
                chk("emit_busy",      128'(busy), 128'(1));
                if (rk_ready) begin
                    beat_key[n_beats]   = rk_out;
                    beat_round[n_beats] = rk_round;
                    n_beats++;
                end else begin
                    held = 1'b1;
                    hk   = rk_out;
                    hr   = rk_round;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        rk_ready = 1'b1;
        chk("beat_count",    128'(n_beats),   128'(11));
        chk("end_rk_valid",  128'(rk_valid),  128'(0));
        chk("end_key_ready", 128'(key_ready), 128'(1));
        chk("end_rk_out",    rk_out,          128'(0));
        chk("end_busy",      128'(busy),      128'(0));
    endtask

    task automatic check_seq(input string tag, input bit zero_key);
        int r;
        for (int i = 0; i < n_beats; i++) begin
            r = 10 - i;
            chk($sformatf("%s_round_idx%0d", tag, i), 128'(beat_round[i]), 128'(r));
            if (zero_key) begin
                if (zero_known[r])
                    chk($sformatf("%s_rk%0d", tag, r), beat_key[i], zero_rk[r]);
            end else begin
                chk($sformatf("%s_rk%0d", tag, r), beat_key[i], fips_rk[r]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // FIPS-197 A.1 round keys, packed low byte first
        fips_rk[0]  = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
        fips_rk[1]  = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
        fips_rk[2]  = 128'h7ff65973_7a803559_43b9967a_f295c2f2;
        fips_rk[3]  = 128'h3b887a6d_447e231e_3efe1647_7d47803d;
        fips_rk[4]  = 128'h00ad0bdb_3b2571b6_7f5b52a8_41a544ef;
        fips_rk[5]  = 128'hbc15f911_bcb8f2ca_879d837c_f8c6d1d4;
        fips_rk[6]  = 128'hfd9300ca_4186f9db_fd3e0b11_7aa3886d;
        fips_rk[7]  = 128'h4fdca64e_b24fa684_f3c95f5f_0ef7544e;
        fips_rk[8]  = 128'h2f298d7f_60f52b31_d2ba8db5_2173d2ea;
        fips_rk[9]  = 128'h6e005c57_4129d128_21dcfa19_f36677ac;
        fips_rk[10] = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;

        // Zero-key expansion. Rounds 1 and 2 are easy to derive by hand. Round
        // 10 is the published b4ef5bcb 3e92e211 23e951cf 6f8f188e, byte-reversed
        // per word.
        for (int i = 0; i <= 10; i++) begin
            zero_rk[i]    = '0;
            zero_known[i] = 1'b0;
        end
        zero_known[0]  = 1'b1;
        zero_known[1]  = 1'b1;
        zero_rk[1]     = 128'h63636362_63636362_63636362_63636362;
        zero_known[2]  = 1'b1;
        zero_rk[2]     = 128'haafbfbf9_c998989b_aafbfbf9_c998989b;
        zero_known[10] = 1'b1;
        zero_rk[10]    = 128'h8e188f6f_cf51e923_11e2923e_cb5befb4;

        rst       = 1'b1;
        key_in    = '0;
        key_last  = 1'b0;
        key_valid = 1'b0;
        rk_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_rk_valid",  128'(rk_valid),  128'(0));
        chk("reset_rk_out",    rk_out,          128'(0));
        chk("reset_rk_round",  128'(rk_round),  128'(0));
        chk("reset_busy",      128'(busy),      128'(0));
        chk("reset_key_ready", 128'(key_ready), 128'(1));

        // cipher key, no backpressure
        send_key(fips_rk[0], 1'b0, 1'b0, '0, 40, lat);
        chk("s1_latency", 128'(lat), 128'(11));
        run_emit(1'b0);
        check_seq("s1", 1'b0);

        // round-10 key loaded directly
        send_key(fips_rk[10], 1'b1, 1'b0, '0, 40, lat);
        chk("s2_latency", 128'(lat), 128'(1));
        run_emit(1'b0);
        check_seq("s2", 1'b0);

        // random backpressure
        send_key(fips_rk[0], 1'b0, 1'b0, '0, 40, lat);
        chk("s3_latency", 128'(lat), 128'(11));
        run_emit(1'b1);
        check_seq("s3", 1'b0);

        // key_valid held with a second (all-zero) key while busy
        send_key(fips_rk[0], 1'b0, 1'b1, '0, 40, lat);
        chk("s4_latency", 128'(lat), 128'(11));
        run_emit(1'b0);
        check_seq("s4", 1'b0);
        send_key('0, 1'b0, 1'b0, '0, 40, lat);
        chk("s6_latency", 128'(lat), 128'(11));
        run_emit(1'b0);
        check_seq("s6", 1'b1);

        // reset during EXPAND at T+5
        send_key(fips_rk[0], 1'b0, 1'b0, '0, 5, lat);
        chk("s5_expand_lat", 128'(lat), 128'(5));
        pulse_reset("s5_rst_expand");
        idle_watch("s5_no_beats_after_expand_rst", 14);

        // reset during EMIT at round 6
        send_key(fips_rk[10], 1'b1, 1'b0, '0, 40, lat);
        begin
            int w;
            w = 0;
            rk_ready = 1'b1;
            while (rk_round != 4'd6 && w < 30) begin
                @(posedge clk); #1;
                w++;
            end
        end
        chk("s5_at_round6",  128'(rk_round), 128'(6));
        chk("s5_round6_key", rk_out, fips_rk[6]);
        pulse_reset("s5_rst_emit");
        idle_watch("s5_no_beats_after_emit_rst", 4);

        send_key(fips_rk[0], 1'b0, 1'b0, '0, 40, lat);
        chk("s5_fresh_latency", 128'(lat), 128'(11));
        run_emit(1'b0);
        check_seq("s5_fresh", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
